// File: rtl/pipe_mux_n_if.sv
// Bundle of data, select, pipeline control and status signals for pipe_mux_n.
// The master side presents inputs and control; the slave side (the mux
// pipeline) returns the selected data, its source index and the error flag.
interface pipe_mux_n_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic                    err_clr;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_src;
    logic                    sel_err;

    modport master (
        output in_bus, sel, in_valid, stall, flush, err_clr,
        input  out, out_valid, out_src, sel_err
    );

    modport slave (
        input  in_bus, sel, in_valid, stall, flush, err_clr,
        output out, out_valid, out_src, sel_err
    );
endinterface

// File: rtl/pipe_mux_n.sv
// NUM_IN-way selector followed by a DEPTH-stage pipeline with stall, flush,
// valid tracking, source tagging and a sticky out-of-range-select flag.
// Selects at or above NUM_IN fall back to the highest input (NUM_IN-1).
// All outputs come straight from flops; nothing combinational reaches them.
module pipe_mux_n #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 1
) (
    input  logic         clk,
    input  logic         reset,
    pipe_mux_n_if.slave  bus
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    logic                   sel_oor_s;
    logic [SEL_W-1:0]       eff_s;
    logic [WIDTH-1:0]       mux_s;
    logic                   err_set_s;

    logic [WIDTH-1:0]       data_q [DEPTH];
    logic [WIDTH-1:0]       data_d [DEPTH];
    logic [SEL_W-1:0]       src_q  [DEPTH];
    logic [SEL_W-1:0]       src_d  [DEPTH];
    logic [DEPTH-1:0]       vld_q;
    logic [DEPTH-1:0]       vld_d;
    logic                   err_q;
    logic                   err_d;

    // Resolve the effective index; out-of-range selects map to the highest input.
    always_comb begin
        if (32'(bus.sel) >= 32'(NUM_IN)) begin
            sel_oor_s = 1'b1;
            eff_s     = LAST_IDX;
        end else begin
            sel_oor_s = 1'b0;
            eff_s     = bus.sel;
        end
    end

    // Pick the input slice addressed by the effective index.
    always_comb begin
        mux_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            mux_s = (eff_s == SEL_W'(i)) ? bus.in_bus[i*WIDTH +: WIDTH] : mux_s;
        end
    end

    // Next pipeline contents: flush kills valids, stall freezes, otherwise shift.
    always_comb begin
        data_d = data_q;
        src_d  = src_q;
        vld_d  = vld_q;
        if (bus.flush) begin
            // Data and source tags are left in place; only validity is dropped.
            vld_d = {DEPTH{1'b0}};
        end else if (!bus.stall) begin
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                data_d[0] = mux_s;
                src_d[0]  = eff_s;
            end else begin
                data_d[0] = data_q[0];
                src_d[0]  = src_q[0];
            end
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
                src_d[k]  = src_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
        end else begin
            data_d = data_q;
            src_d  = src_q;
            vld_d  = vld_q;
        end
    end

    // Sticky error: an accepted out-of-range select sets it, set beats clear.
    always_comb begin
        err_set_s = bus.in_valid & ~bus.stall & ~bus.flush & sel_oor_s;
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= {WIDTH{1'b0}};
                src_q[k]  <= {SEL_W{1'b0}};
            end
            vld_q <= {DEPTH{1'b0}};
        end else begin
            data_q <= data_d;
            src_q  <= src_d;
            vld_q  <= vld_d;
        end
    end

    // Error flag register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.out       = data_q[DEPTH-1];
    assign bus.out_src   = src_q[DEPTH-1];
    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Scoreboard bench for pipe_mux_n. Three configurations run side by side on
// shared control (in_valid/stall/flush/err_clr/reset) with per-instance data:
//   cfg0: NUM_IN=4 SEL_W=2 DEPTH=1   cfg1: NUM_IN=5 SEL_W=3 DEPTH=3
//   cfg2: NUM_IN=4 SEL_W=2 DEPTH=2
// Reference: each accepted input is numbered by the count of advancing edges
// (no stall, no flush); it must appear after advancing edge number n+DEPTH-1
// unless a flush or reset intervened. Output data while invalid is the most
// recent capture at or before that point (data registers never clear on flush).
module tb_pipe_mux_n;

    localparam int W = 5;
    localparam int K_RST   = 0;
    localparam int K_STALL = 1;
    localparam int K_FLUSH = 2;
    localparam int K_ADV   = 3;

    logic clk;
    logic reset;
    logic in_valid, stall, flush, err_clr;
    bit   dir_en;
    int   dir_sel;
    logic [W-1:0] dir_bus [5];

    int n_cmp;
    int n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input int cfg, input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", cfg, nm, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int N = (g == 1) ? 5 : 4;
        localparam int S = (g == 1) ? 3 : 2;
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 3 : 2);

        typedef struct packed {
            int           e;
            logic [W-1:0] d;
            logic [S-1:0] s;
        } ent_t;

        pipe_mux_n_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) mif ();

        pipe_mux_n #(.WIDTH(W), .NUM_IN(N), .SEL_W(S), .DEPTH(D)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (mif.slave)
        );

        logic [N*W-1:0] bus_v;
        logic [S-1:0]   sel_v;

        assign mif.in_bus   = bus_v;
        assign mif.sel      = sel_v;
        assign mif.in_valid = in_valid;
        assign mif.stall    = stall;
        assign mif.flush    = flush;
        assign mif.err_clr  = err_clr;

        ent_t exp_q [$];
        ent_t hist  [$];
        int   kind = K_RST;
        int   adv  = 0;
        bit   err_m = 1'b0;
        logic [W-1:0] p_out;
        logic         p_v;
        logic [S-1:0] p_src;

        initial begin
            if ((1 << S) < N) begin
                $display("FAIL cfg%0d param: 2**SEL_W=%0d below NUM_IN=%0d", g, 1 << S, N);
                $fatal(1, "bad parameters");
            end
        end

        // Per-instance data/select driver, updated just after each falling edge.
        initial begin
            bus_v = '0;
            sel_v = '0;
            forever begin
                @(negedge clk);
                #1;
                if (dir_en) begin
                    for (int i = 0; i < N; i++) bus_v[i*W +: W] = dir_bus[i];
                    sel_v = S'(dir_sel);
                end else begin
                    for (int i = 0; i < N; i++) bus_v[i*W +: W] = W'($urandom);
                    sel_v = S'($urandom);
                end
            end
        end

        // Issue side: classify each edge and push expected results.
        always @(posedge clk) begin
            int   eff;
            ent_t ent;
            if (!reset) begin
                kind = K_RST;
            end else begin
                if (in_valid && !stall && !flush && int'(sel_v) >= N) err_m = 1'b1;
                else if (err_clr) err_m = 1'b0;
                if (flush) begin
                    kind = K_FLUSH;
                    exp_q.delete();
                end else if (stall) begin
                    kind = K_STALL;
                end else begin
                    adv++;
                    kind = K_ADV;
                    if (in_valid) begin
                        eff   = (int'(sel_v) >= N) ? N - 1 : int'(sel_v);
                        ent.e = adv;
                        ent.d = bus_v[eff*W +: W];
                        ent.s = S'(eff);
                        exp_q.push_back(ent);
                        hist.push_back(ent);
                    end
                end
            end
        end

        // Asynchronous reset: everything in flight is lost, outputs clear at once.
        always @(negedge reset) begin
            exp_q.delete();
            hist.delete();
            err_m = 1'b0;
            #1;
            chk(g, "rst_out",   int'(mif.out), 0);
            chk(g, "rst_valid", int'(mif.out_valid), 0);
            chk(g, "rst_src",   int'(mif.out_src), 0);
            chk(g, "rst_err",   int'(mif.sel_err), 0);
        end

        // Monitor: sample outputs 2 time units after each rising edge.
        always @(posedge clk) begin
            int   due;
            int   hd;
            int   hs;
            ent_t ent;
            #2;
            case (kind)
                K_RST: begin
                    chk(g, "rsthold_out",   int'(mif.out), 0);
                    chk(g, "rsthold_valid", int'(mif.out_valid), 0);
                    chk(g, "rsthold_src",   int'(mif.out_src), 0);
                end
                K_STALL: begin
                    chk(g, "stall_out",   int'(mif.out), int'(p_out));
                    chk(g, "stall_valid", int'(mif.out_valid), int'(p_v));
                    chk(g, "stall_src",   int'(mif.out_src), int'(p_src));
                end
                K_FLUSH: begin
                    chk(g, "flush_valid", int'(mif.out_valid), 0);
                    chk(g, "flush_out",   int'(mif.out), int'(p_out));
                    chk(g, "flush_src",   int'(mif.out_src), int'(p_src));
                end
                K_ADV: begin
                    due = adv - D + 1;
                    if (mif.out_valid) begin
                        if (exp_q.size() == 0) begin
                            chk(g, "spurious_valid", 1, 0);
                        end else begin
                            ent = exp_q.pop_front();
                            chk(g, "latency", due, ent.e);
                            chk(g, "data",    int'(mif.out), int'(ent.d));
                            chk(g, "src",     int'(mif.out_src), int'(ent.s));
                        end
                    end else begin
                        if (exp_q.size() > 0 && exp_q[0].e <= due) begin
                            chk(g, "missing_valid", 0, 1);
                            void'(exp_q.pop_front());
                        end
                        hd = 0;
                        hs = 0;
                        for (int i = hist.size() - 1; i >= 0; i--) begin
                            if (hist[i].e <= due) begin
                                hd = int'(hist[i].d);
                                hs = int'(hist[i].s);
                                break;
                            end
                        end
                        chk(g, "bubble_out", int'(mif.out), hd);
                        chk(g, "bubble_src", int'(mif.out_src), hs);
                    end
                end
                default: ;
            endcase
            chk(g, "sel_err", int'(mif.sel_err), int'(err_m));
            p_out = mif.out;
            p_v   = mif.out_valid;
            p_src = mif.out_src;
        end
    end

    task automatic step(input bit v, input bit st, input bit fl, input bit ec, input int s);
        @(negedge clk);
        in_valid = v;
        stall    = st;
        flush    = fl;
        err_clr  = ec;
        dir_sel  = s;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
        dir_en   = 1'b1;
        dir_sel  = 0;
        dir_bus  = '{5'd31, 5'd8, 5'd17, 5'd3, 5'h1A};
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Walk the select through every input, then a bubble.
        for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 1'b0, 1'b0, s);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Out-of-range select, then clear the sticky flag.
        step(1'b1, 1'b0, 1'b0, 1'b0, 6);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Stall: A is accepted, B is presented only while stalled.
        dir_bus[0] = 5'd9;
        dir_bus[1] = 5'd12;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Three words streamed, a fourth dropped by flush.
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 1'b0, 1'b0, s);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Reset asserted between edges mid-stream.
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 1'b0, 1'b0, s);
        #2 reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Error set and clear in the same cycle, then a bubble.
        step(1'b1, 1'b0, 1'b0, 1'b1, 7);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Randomised traffic with one mid-run reset.
        dir_en = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) != 0, ($urandom % 7) == 0, ($urandom % 20) == 0,
                 ($urandom % 20) == 0, 0);
            if (i == 700) begin
                #2 reset = 1'b0;
            end
            if (i == 703) reset = 1'b1;
        end
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised successor to the fixed 4-input register-destination mux, used for register-file write-back destination and ALU operand source selection.
- Selects one of NUM_IN inputs of WIDTH bits, then carries the result through a DEPTH-stage pipeline.
- The pipeline supports stall, flush, valid tracking, source-index tagging and a sticky out-of-range-select error.
- Sits between the control unit and the register file / ALU in the multicycle datapath.

Parameters:
- WIDTH, 5, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width. Must satisfy 2**SEL_W >= NUM_IN; the bench checks this at elaboration.
- DEPTH, 1, number of pipeline register stages; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion clears the block immediately; deassertion is synchronised externally.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  input index.
- in_valid  input  1  qualifies in_bus and sel this cycle.
- stall  input  1  freezes every pipeline stage.
- flush  input  1  invalidates every pipeline stage.
- err_clr  input  1  clears sel_err.
- out  output  WIDTH  selected data from the last stage.
- out_valid  output  1  out is meaningful.
- out_src  output  SEL_W  effective index that produced out.
- sel_err  output  1  sticky flag: an out-of-range select was accepted.

Behaviour:
- Reset (reset=0, asynchronous): every stage's data, src and valid clear to 0. Outputs are out=0, out_valid=0, out_src=0, sel_err=0.
- Select rule:
  - If sel < NUM_IN, the effective index is sel.
  - If sel >= NUM_IN, the effective index is NUM_IN-1. This generalises the old "else" branch, which returned the highest input.
  - Selection is purely combinational on the stage-0 input side.
- Stage 0 capture, at a rising edge with stall=0 and flush=0:
  - v0 <= in_valid.
  - If in_valid=1, d0 <= in_bus[eff*WIDTH +: WIDTH] and s0 <= eff.
  - If in_valid=0, d0 and s0 hold their previous values; only the valid bit drops.
- Stage k (k=1..DEPTH-1): at an edge with stall=0 and flush=0, shifts {d,s,v}(k-1) into stage k.
- Outputs come from stage DEPTH-1.
- Latency: an accepted input appears on out/out_valid exactly DEPTH cycles later.
- Throughput: one transfer per cycle when stall=0.
- Stall: all stages hold, including the valid bits, and inputs are ignored. The outputs stay stable for the whole stall.
- Flush:
  - At the edge, all valid bits go to 0. Data and src registers hold.
  - Flush has priority over stall and over in_valid; an input presented in the flush cycle is dropped.
  - out_valid=0 from the cycle after the flush edge until a new accepted input has propagated through (DEPTH cycles).
- sel_err:
  - Set at the edge where in_valid=1, stall=0, flush=0 and sel >= NUM_IN.
  - Cleared by err_clr=1 at an edge.
  - If set and clear coincide, set wins.
  - Independent of pipeline progress.
  - Never set when NUM_IN = 2**SEL_W.
- Reset mid-operation: all in-flight entries are lost and out_valid drops to 0 asynchronously. There is no residual output after reset releases.
- No combinational path from any input to any output.

Test Plan:
- NUM_IN=4, WIDTH=5, DEPTH=1; in_bus={5'd3,5'd17,5'd8,5'd31}, i.e. input0=31 … input3=3; sel steps 0,1,2,3 with in_valid=1 -> one cycle later out=31,8,17,3, out_src=0,1,2,3, out_valid=1 each cycle.
- NUM_IN=5, SEL_W=3, DEPTH=3; sel=6 with input4=5'h1A -> out=5'h1A, out_src=4 after exactly 3 cycles; sel_err=1 from the next edge; err_clr pulse -> sel_err=0.
- DEPTH=2; accept A=5'd9, then assert stall for 4 cycles while presenting B=5'd12 -> no output change during the stall; after release A emerges, and B is never seen unless re-presented.
- DEPTH=3; stream 3 valid words, assert flush with a 4th word -> out_valid=0 from the next cycle for 3 cycles; the 4th word is never output.
- Assert reset low asynchronously mid-stream (between edges) -> out=0, out_valid=0, out_src=0, sel_err=0 immediately; the first valid output after release comes DEPTH cycles after the first accepted input.
- Simultaneous err_clr=1 and sel=7 (NUM_IN=5) -> sel_err=1; a bubble (in_valid=0) -> out_valid=0 while out holds its last data.
